wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost cycles after which requester 1 is boosted; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_ena  input  1  arbitration enable; 0 = no grants, outputs cleared.
REQ-005 i_req0_valid  input  1  pipeline writeback request valid.
REQ-006 i_req0_rd / i_req0_rd_wen / i_req0_rd_wdata  input  `BUS_RIDX / 1 / `BUS_64  requester-0 payload.
REQ-007 o_req0_ready  output  1  requester-0 payload consumed this cycle.
REQ-008 i_req1_valid  input  1  long-latency unit (mul/div) writeback request valid.
REQ-009 i_req1_rd / i_req1_rd_wen / i_req1_rd_wdata  input  `BUS_RIDX / 1 / `BUS_64  requester-1 payload.
REQ-010 o_req1_ready  output  1  requester-1 payload consumed this cycle.
REQ-011 o_rd / o_rd_wen / o_rd_wdata  output  `BUS_RIDX / 1 / `BUS_64  registered regfile write port.
REQ-012 o_valid  output  1  registered; a granted request occupies the write port this cycle.
REQ-013 o_src  output  1  registered; source of current o_valid beat (0/1).

Function
REQ-014 Handshake: transfer on a requester = valid & ready, both combinational in the same cycle; requester SHALL hold payload stable while valid & !ready.
REQ-015 At most one ready asserted per cycle; ready is never asserted when the requester's valid is 0.
REQ-016 i_ena=0: both ready=0; next-cycle o_valid=0, o_rd=0, o_rd_wen=0, o_rd_wdata=0; FSM state and starvation counter hold.
REQ-017 FSM states PRI0 (requester 0 wins ties) and PRI1 (requester 1 wins ties); only one valid -> that one granted in either state.
REQ-018 PRI0 -> PRI1 when starvation counter reaches STARVE_LIMIT; PRI1 -> PRI0 on the cycle requester 1 is granted.
REQ-019 Starvation counter: increments when i_ena & i_req1_valid & !o_req1_ready, saturating at STARVE_LIMIT; cleared on requester-1 grant.
REQ-020 Latency: payload granted in cycle N appears on o_rd/o_rd_wen/o_rd_wdata/o_valid/o_src in cycle N+1; one beat per grant, back-to-back grants allowed every cycle.
REQ-021 No grant with i_ena=1: next-cycle o_valid=0, o_rd_wen=0, o_rd=0, o_rd_wdata=0.
REQ-022 x0 rule: granted payload with rd=0 is consumed and o_valid=1, but o_rd_wen=0 and o_rd_wdata=0.
REQ-023 Granted payload with rd_wen=0 is consumed; o_valid=1, o_rd_wen=0, o_rd/o_rd_wdata pass through.
REQ-024 Grant decision depends only on current inputs and registered state; no combinational path from o_* outputs back to ready.

Reset
REQ-025 rst=1 at a rising edge: FSM=PRI0, counter=0, o_valid=0, o_src=0, o_rd=0, o_rd_wen=0, o_rd_wdata=0.
REQ-026 While rst=1 both ready outputs SHALL be 0; requests presented during reset are not consumed.
REQ-027 Reset mid-stream discards any beat that would have appeared the following cycle.

Structure
REQ-028 Bus widths `BUS_RIDX (5b) and `BUS_64 (64b) come from the shared defines.v; FSM state encodings and STARVE_LIMIT default defined there.
REQ-029 One natural sub-module: wb_starve_cnt (saturating counter with clear, limit-reached flag); remaining logic flat.

Verification
REQ-030 Only req1 valid (rd=5, wdata=0x1234) with i_ena=1 -> req1_ready same cycle; next cycle o_valid=1, o_src=1, o_rd=5, o_rd_wen=1, o_rd_wdata=0x1234.
REQ-031 Both valid continuously, STARVE_LIMIT=4 -> req0 granted cycles 0-3, req1 granted cycle 4, req0 granted cycle 5; counter 0 after cycle 4.
REQ-032 req0 rd=0 wen=1 wdata=0xFFFF -> consumed; next cycle o_valid=1, o_rd_wen=0, o_rd_wdata=0.
REQ-033 Both valid with i_ena=0 for 3 cycles -> no ready, outputs all zero, counter unchanged; on i_ena=1 arbitration resumes from prior state.
REQ-034 Counter at 3 in PRI0, rst asserted one cycle -> next cycle state PRI0, counter 0, o_valid=0; req0 wins the first tie after reset.
REQ-035 req0 valid every cycle, req1 valid once held 10 cycles -> req1 granted no later than cycle STARVE_LIMIT (4) after first valid, payload stable until then.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
// Shared types and constants for the writeback-port arbiter:
//   BUS_RIDX / BUS_64      register-index and write-data widths
//   STARVE_LIMIT_DEFAULT   default boost threshold for requester 1
//   CNT_W                  width of the starvation counter (limit range 1..15)
//   arb_state_e            tie-break priority state (PRI0 / PRI1)
//   wb_beat_t              one registered write-port beat
//   make_beat()            builds a beat and applies the x0 rule
package wb_arbiter_pkg;

  localparam int unsigned BUS_RIDX             = 5;
  localparam int unsigned BUS_64               = 64;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned CNT_W                = 4;

  typedef enum logic [0:0] {
    PRI0 = 1'b0,  // requester 0 wins ties
    PRI1 = 1'b1   // requester 1 wins ties
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic                src;
    logic [BUS_RIDX-1:0] rd;
    logic                wen;
    logic [BUS_64-1:0]   wdata;
  } wb_beat_t;

  // A beat targeting x0 is still consumed and reported valid, but must
  // never write: enable and data are forced to zero.
  function automatic wb_beat_t make_beat(
    input logic                src,
    input logic [BUS_RIDX-1:0] rd,
    input logic                wen,
    input logic [BUS_64-1:0]   wdata
  );
    wb_beat_t b;
    b.valid = 1'b1;
    b.src   = src;
    b.rd    = rd;
    if (rd == {BUS_RIDX{1'b0}}) begin
      b.wen   = 1'b0;
      b.wdata = {BUS_64{1'b0}};
    end else begin
      b.wen   = wen;
      b.wdata = wdata;
    end
    return b;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
// Bundles the two writeback requesters and the regfile write port.
//   i_req0_*  requester 0 (pipeline writeback): valid + rd/rd_wen/rd_wdata
//   o_req0_ready  requester 0 consumed this cycle
//   i_req1_*  requester 1 (mul/div writeback): valid + rd/rd_wen/rd_wdata
//   o_req1_ready  requester 1 consumed this cycle
//   o_rd/o_rd_wen/o_rd_wdata/o_valid/o_src  registered write port
// Modports: master = requester/consumer side, slave = arbiter side.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                i_req0_valid;
  logic [BUS_RIDX-1:0] i_req0_rd;
  logic                i_req0_rd_wen;
  logic [BUS_64-1:0]   i_req0_rd_wdata;
  logic                o_req0_ready;

  logic                i_req1_valid;
  logic [BUS_RIDX-1:0] i_req1_rd;
  logic                i_req1_rd_wen;
  logic [BUS_64-1:0]   i_req1_rd_wdata;
  logic                o_req1_ready;

  logic [BUS_RIDX-1:0] o_rd;
  logic                o_rd_wen;
  logic [BUS_64-1:0]   o_rd_wdata;
  logic                o_valid;
  logic                o_src;

  modport master (
    output i_req0_valid, i_req0_rd, i_req0_rd_wen, i_req0_rd_wdata,
    output i_req1_valid, i_req1_rd, i_req1_rd_wen, i_req1_rd_wdata,
    input  o_req0_ready, o_req1_ready,
    input  o_rd, o_rd_wen, o_rd_wdata, o_valid, o_src
  );

  modport slave (
    input  i_req0_valid, i_req0_rd, i_req0_rd_wen, i_req0_rd_wdata,
    input  i_req1_valid, i_req1_rd, i_req1_rd_wen, i_req1_rd_wdata,
    output o_req0_ready, o_req1_ready,
    output o_rd, o_rd_wen, o_rd_wdata, o_valid, o_src
  );

endinterface

// File: rtl/wb_starve_cnt.sv
// wb_starve_cnt
// Saturating counter of consecutive cycles requester 1 was refused.
//   clk, rst  clock, synchronous active-high reset
//   i_inc     requester 1 waited this cycle
//   i_clr     requester 1 was granted this cycle (wins over i_inc)
//   o_hit     the count lands on LIMIT at the coming edge
module wb_starve_cnt
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // next count: clear on grant, saturating increment on a refused request
  always_comb begin
    cnt_next_s = cnt_r;
    if (i_clr) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (i_inc && (cnt_r < LIMIT_C)) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  // Flag only the transition onto the limit so the FSM boosts exactly once
  // per starvation episode.
  assign o_hit = (cnt_next_s == LIMIT_C) && (cnt_r != LIMIT_C);

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Two-requester arbiter for the register-file write port. Requester 0 wins
// ties until requester 1 has been refused STARVE_LIMIT cycles in a row; the
// tie-break then flips to requester 1 until it is granted once.
//   clk, rst  clock, synchronous active-high reset
//   i_ena     arbitration enable (0: no grants, write port cleared)
//   bus       wb_arbiter_if.slave: requester handshakes + registered port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ena,
  wb_arbiter_if.slave  bus
);

  arb_state_e state_r;
  arb_state_e state_next_s;
  logic       grant0_s;
  logic       grant1_s;
  logic       cnt_inc_s;
  logic       cnt_hit_s;
  wb_beat_t   beat_next_s;
  wb_beat_t   beat_r;

  // grant decision from current valids and registered tie-break state only
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst || !i_ena) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (bus.i_req0_valid && bus.i_req1_valid) begin
      if (state_r == PRI1) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b1;
      end
    end else if (bus.i_req0_valid) begin
      grant0_s = 1'b1;
    end else if (bus.i_req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign cnt_inc_s = !rst && i_ena && bus.i_req1_valid && !grant1_s;

  wb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (cnt_inc_s),
    .i_clr (grant1_s),
    .o_hit (cnt_hit_s)
  );

  // tie-break FSM next state; with i_ena=0 neither input moves it
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      PRI0: begin
        if (cnt_hit_s) begin
          state_next_s = PRI1;
        end else begin
          state_next_s = PRI0;
        end
      end
      PRI1: begin
        if (grant1_s) begin
          state_next_s = PRI0;
        end else begin
          state_next_s = PRI1;
        end
      end
      default: begin
        state_next_s = PRI0;
      end
    endcase
  end

  // beat for the write port; idle cycles produce an all-zero beat
  always_comb begin
    beat_next_s = '0;
    if (grant0_s) begin
      beat_next_s = make_beat(1'b0, bus.i_req0_rd, bus.i_req0_rd_wen,
                              bus.i_req0_rd_wdata);
    end else if (grant1_s) begin
      beat_next_s = make_beat(1'b1, bus.i_req1_rd, bus.i_req1_rd_wen,
                              bus.i_req1_rd_wdata);
    end else begin
      beat_next_s = '0;
    end
  end

  // state and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PRI0;
      beat_r  <= '0;
    end else begin
      state_r <= state_next_s;
      beat_r  <= beat_next_s;
    end
  end

  assign bus.o_req0_ready = grant0_s;
  assign bus.o_req1_ready = grant1_s;
  assign bus.o_valid      = beat_r.valid;
  assign bus.o_src        = beat_r.src;
  assign bus.o_rd         = beat_r.rd;
  assign bus.o_rd_wen     = beat_r.wen;
  assign bus.o_rd_wdata   = beat_r.wdata;

endmodule
